// File: rtl/counter_seq.sv
// Sequencer for an external loadable counter: preloads it, paces its increments
// through a prescaler and reports terminal-count events (one-shot or periodic).
module counter_seq #(
   parameter int WIDTH = 8,
   parameter int PW    = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic             mode,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] limit,
   input  logic [PW-1:0]    presc,
   input  logic [WIDTH-1:0] cnt_val,
   output logic             cnt_cen,
   output logic             cnt_wen,
   output logic [WIDTH-1:0] cnt_dat,
   output logic             busy,
   output logic             done,
   output logic [15:0]      periods
);

   typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

   state_t           r_state;
   logic             r_mode;
   logic [WIDTH-1:0] r_load;
   logic [WIDTH-1:0] r_limit;
   logic [PW-1:0]    r_presc;
   logic [PW-1:0]    r_pcnt;
   logic             r_wen;
   logic             r_busy;
   logic             r_done;
   logic [15:0]      r_periods;

   logic             w_tick;
   logic             w_atLimit;

   assign w_tick    = (r_pcnt == r_presc);
   assign w_atLimit = (cnt_val == r_limit);

   // Enable is combinational on the live counter value so the counter never steps past the limit.
   assign cnt_cen = (r_state == RUN) && w_tick && !w_atLimit;
   assign cnt_wen = r_wen;
   assign cnt_dat = r_load;
   assign busy    = r_busy;
   assign done    = r_done;
   assign periods = r_periods;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_mode    <= 1'b0;
         r_load    <= '0;
         r_limit   <= '0;
         r_presc   <= '0;
         r_pcnt    <= '0;
         r_wen     <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_periods <= '0;
      end else begin
         r_done <= 1'b0;
         // Abort has priority over every transition, including a same-cycle terminal count.
         if (stop) begin
            r_state <= IDLE;
            r_wen   <= 1'b0;
            r_busy  <= 1'b0;
         end else begin
            case (r_state)
               IDLE: begin
                  if (start) begin
                     r_mode    <= mode;
                     r_load    <= load_val;
                     r_limit   <= limit;
                     r_presc   <= presc;
                     r_periods <= '0;
                     r_state   <= LOAD;
                     r_wen     <= 1'b1;
                     r_busy    <= 1'b1;
                  end
               end
               LOAD: begin
                  r_pcnt  <= '0;
                  r_state <= RUN;
                  r_wen   <= 1'b0;
               end
               RUN: begin
                  if (w_tick) begin
                     r_pcnt <= '0;
                     if (w_atLimit) begin
                        r_done <= 1'b1;
                        if (r_periods != 16'hFFFF) begin
                           r_periods <= r_periods + 16'd1;
                        end
                        if (r_mode) begin
                           r_state <= LOAD;
                           r_wen   <= 1'b1;
                        end else begin
                           r_state <= IDLE;
                           r_busy  <= 1'b0;
                        end
                     end
                  end else begin
                     r_pcnt <= r_pcnt + PW'(1);
                  end
               end
               default: begin
                  r_state <= IDLE;
                  r_wen   <= 1'b0;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_counter_seq.sv
// Self-checking bench for counter_seq: a cycle table for one-shot, wrap, equal
// load/limit and start+stop cases, plus hand-written periodic, abort and reset sequences.
module tb_counter_seq;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        stop;
   logic        mode;
   logic [7:0]  load_val;
   logic [7:0]  limit;
   logic [3:0]  presc;
   logic [7:0]  cnt_val;
   logic        cnt_cen;
   logic        cnt_wen;
   logic [7:0]  cnt_dat;
   logic        busy;
   logic        done;
   logic [15:0] periods;

   int errors;
   int checks;

   typedef struct {
      logic       start;
      logic       stop;
      logic       mode;
      logic [7:0] ld;
      logic [7:0] lim;
      logic [3:0] pr;
      logic [7:0] eVal;
      logic       eBusy;
      logic       eDone;
      logic       eWen;
      logic       eCen;
      logic [15:0] ePer;
      logic [7:0] eDat;
   } vec_t;

   vec_t vecs[$];

   counter_seq #(.WIDTH(8), .PW(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .stop     (stop),
      .mode     (mode),
      .load_val (load_val),
      .limit    (limit),
      .presc    (presc),
      .cnt_val  (cnt_val),
      .cnt_cen  (cnt_cen),
      .cnt_wen  (cnt_wen),
      .cnt_dat  (cnt_dat),
      .busy     (busy),
      .done     (done),
      .periods  (periods)
   );

   // Free-running clock, period 10.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model of the external loadable counter the sequencer drives.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_val <= 8'h00;
      end else if (cnt_wen) begin
         cnt_val <= cnt_dat;
      end else if (cnt_cen) begin
         cnt_val <= cnt_val + 8'd1;
      end
   end

   function automatic vec_t mkVec(logic st, logic sp, logic md, logic [7:0] ld, logic [7:0] lim,
                                  logic [3:0] pr, logic [7:0] eVal, logic eBusy, logic eDone,
                                  logic eWen, logic eCen, logic [15:0] ePer, logic [7:0] eDat);
      vec_t v;
      v.start = st;  v.stop = sp;  v.mode = md;  v.ld = ld;  v.lim = lim;  v.pr = pr;
      v.eVal = eVal; v.eBusy = eBusy; v.eDone = eDone; v.eWen = eWen; v.eCen = eCen;
      v.ePer = ePer; v.eDat = eDat;
      return v;
   endfunction

   function automatic logic [63:0] packOut();
      return {24'h0, cnt_val, cnt_dat, 4'h0, busy, done, cnt_wen, cnt_cen, periods};
   endfunction

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      start    = v.start;
      stop     = v.stop;
      mode     = v.mode;
      load_val = v.ld;
      limit    = v.lim;
      presc    = v.pr;
      stepCycle();
   endtask

   initial begin
      logic [7:0] perSeq [6];
      logic [63:0] expOut;
      vec_t v;

      errors = 0;
      checks = 0;
      rst_n = 1'b0;
      start = 1'b0;
      stop = 1'b0;
      mode = 1'b0;
      load_val = 8'h00;
      limit = 8'h00;
      presc = 4'h0;
      perSeq = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd2};

      // start, stop, mode, ld, lim, pr | val, busy, done, wen, cen, periods, dat
      vecs.push_back(mkVec(1,0,0,8'h03,8'h07,4'h0, 8'h00,1,0,1,0,16'd0,8'h03));
      vecs.push_back(mkVec(0,0,0,8'h03,8'h07,4'h0, 8'h03,1,0,0,1,16'd0,8'h03));
      vecs.push_back(mkVec(1,0,1,8'h55,8'h10,4'h3, 8'h04,1,0,0,1,16'd0,8'h03));
      vecs.push_back(mkVec(0,0,0,8'h03,8'h07,4'h0, 8'h05,1,0,0,1,16'd0,8'h03));
      vecs.push_back(mkVec(0,0,0,8'h03,8'h07,4'h0, 8'h06,1,0,0,1,16'd0,8'h03));
      vecs.push_back(mkVec(0,0,0,8'h03,8'h07,4'h0, 8'h07,1,0,0,0,16'd0,8'h03));
      vecs.push_back(mkVec(0,0,0,8'h03,8'h07,4'h0, 8'h07,0,1,0,0,16'd1,8'h03));
      vecs.push_back(mkVec(0,0,0,8'h03,8'h07,4'h0, 8'h07,0,0,0,0,16'd1,8'h03));
      vecs.push_back(mkVec(1,0,0,8'hFE,8'h01,4'h0, 8'h07,1,0,1,0,16'd0,8'hFE));
      vecs.push_back(mkVec(0,0,0,8'hFE,8'h01,4'h0, 8'hFE,1,0,0,1,16'd0,8'hFE));
      vecs.push_back(mkVec(0,0,0,8'hFE,8'h01,4'h0, 8'hFF,1,0,0,1,16'd0,8'hFE));
      vecs.push_back(mkVec(0,0,0,8'hFE,8'h01,4'h0, 8'h00,1,0,0,1,16'd0,8'hFE));
      vecs.push_back(mkVec(0,0,0,8'hFE,8'h01,4'h0, 8'h01,1,0,0,0,16'd0,8'hFE));
      vecs.push_back(mkVec(0,0,0,8'hFE,8'h01,4'h0, 8'h01,0,1,0,0,16'd1,8'hFE));
      vecs.push_back(mkVec(0,0,0,8'hFE,8'h01,4'h0, 8'h01,0,0,0,0,16'd1,8'hFE));
      vecs.push_back(mkVec(1,0,0,8'h05,8'h05,4'h0, 8'h01,1,0,1,0,16'd0,8'h05));
      vecs.push_back(mkVec(0,0,0,8'h05,8'h05,4'h0, 8'h05,1,0,0,0,16'd0,8'h05));
      vecs.push_back(mkVec(0,0,0,8'h05,8'h05,4'h0, 8'h05,0,1,0,0,16'd1,8'h05));
      vecs.push_back(mkVec(0,0,0,8'h05,8'h05,4'h0, 8'h05,0,0,0,0,16'd1,8'h05));
      vecs.push_back(mkVec(1,1,0,8'h09,8'h09,4'h0, 8'h05,0,0,0,0,16'd1,8'h05));
      vecs.push_back(mkVec(0,0,0,8'h09,8'h09,4'h0, 8'h05,0,0,0,0,16'd1,8'h05));

      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset state", packOut(), 64'h0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         applyStimulus(v);
         expOut = {24'h0, v.eVal, v.eDat, 4'h0, v.eBusy, v.eDone, v.eWen, v.eCen, v.ePer};
         checkOutput($sformatf("table row %0d", i), packOut(), expOut);
      end

      // Periodic: load 0, limit 2, presc 1 gives a done every 7 cycles.
      start = 1'b1; stop = 1'b0; mode = 1'b1; load_val = 8'h00; limit = 8'h02; presc = 4'h1;
      stepCycle();
      start = 1'b0;
      checkOutput("periodic load cycle", {62'h0, cnt_wen, busy}, 64'h3);
      for (int k = 1; k <= 21; k++) begin
         stepCycle();
         checkOutput($sformatf("periodic done k=%0d", k), {63'h0, done}, {63'h0, (k % 7) == 0});
         if (k <= 6) begin
            checkOutput($sformatf("periodic cnt_val k=%0d", k), {56'h0, cnt_val}, {56'h0, perSeq[k-1]});
         end
      end
      checkOutput("periodic periods", {48'h0, periods}, 64'd3);
      stop = 1'b1;
      stepCycle();
      stop = 1'b0;
      checkOutput("periodic stop", {busy, done, 46'h0, periods}, {2'b00, 46'h0, 16'd3});
      stepCycle();
      checkOutput("periodic idle hold", {busy, done, 46'h0, periods}, {2'b00, 46'h0, 16'd3});

      // Stop coinciding with the second terminal count of a periodic run.
      start = 1'b1; mode = 1'b1; load_val = 8'h03; limit = 8'h04; presc = 4'h0;
      stepCycle();
      start = 1'b0;
      repeat (3) stepCycle();
      checkOutput("first terminal", {done, 47'h0, periods}, {1'b1, 47'h0, 16'd1});
      repeat (2) stepCycle();
      checkOutput("at limit before stop", {56'h0, cnt_val}, 64'h04);
      stop = 1'b1;
      stepCycle();
      stop = 1'b0;
      checkOutput("stop on terminal", {busy, done, 46'h0, periods}, {2'b00, 46'h0, 16'd1});
      stepCycle();
      checkOutput("no late done", {busy, done, 46'h0, periods}, {2'b00, 46'h0, 16'd1});

      // Asynchronous reset in the middle of a periodic run.
      start = 1'b1; mode = 1'b1; load_val = 8'h00; limit = 8'h00; presc = 4'h0;
      stepCycle();
      start = 1'b0;
      repeat (4) stepCycle();
      checkOutput("pre-reset periods", {48'h0, periods}, 64'd2);
      stepCycle();
      checkOutput("pre-reset busy", {63'h0, busy}, 64'h1);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("async reset outputs",
                  {40'h0, cnt_dat, busy, done, cnt_wen, cnt_cen, periods}, 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      stepCycle();
      checkOutput("no resume after reset", {62'h0, busy, cnt_wen}, 64'h0);

      start = 1'b1; mode = 1'b0; load_val = 8'h0A; limit = 8'h0C; presc = 4'h2;
      stepCycle();
      start = 1'b0;
      checkOutput("restart load", {55'h0, cnt_wen, cnt_dat}, {55'h0, 1'b1, 8'h0A});
      for (int k = 1; k <= 10; k++) begin
         stepCycle();
         checkOutput($sformatf("restart done/busy k=%0d", k), {62'h0, done, busy},
                     {62'h0, k == 10, k < 10});
         if (k == 1 || k == 4 || k == 7) begin
            checkOutput($sformatf("restart cnt_val k=%0d", k), {56'h0, cnt_val},
                        {56'h0, 8'h0A + 8'((k - 1) / 3)});
         end
      end
      checkOutput("restart periods", {48'h0, periods}, 64'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
